seq_signed_div: RTL

- Multi-cycle signed integer divider. It is the inverse operation of the team's exact_mult block.
- Takes a signed DW-bit dividend (normally a product from exact_mult) and a signed VW-bit divisor. Returns quotient and remainder with C-style truncation toward zero.
- Implementation is a one-bit-per-cycle restoring divider behind valid/ready handshakes.
- Sits downstream of exact_mult in the LR datapath, and in benches as the round-trip checker: (a*b)/b == a.

---
 rtl/seq_div_pkg.sv | 20 ++
 rtl/div_step.sv | 28 ++
 rtl/seq_signed_div.sv | 125 ++++++++++++
 3 files changed

// File: rtl/seq_div_pkg.sv
// Shared parameters, state encoding and sizing helper for the sequential signed divider.
package seq_div_pkg;

  localparam int unsigned DW_DEF = 16;
  localparam int unsigned VW_DEF = 8;
  localparam int unsigned CW_DEF = $clog2(DW_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Iteration counter width; a one-bit dividend still needs a one-bit counter.
  function automatic int unsigned cnt_width(input int unsigned dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
  parameter int unsigned W = 9
) (
  input  logic [W-1:0] prem,
  input  logic         din,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_next_c,
  output logic         q_bit_c
);

  logic [W:0] trial;
  logic [W:0] dvs_ext;

  assign trial   = {prem, din};
  assign dvs_ext = {1'b0, dvs};

  // prem < dvs on entry, so the kept remainder always fits back into W bits.
  always_comb begin
    q_bit_c    = 1'b0;
    rem_next_c = W'(trial);
    if (trial >= dvs_ext) begin
      q_bit_c    = 1'b1;
      rem_next_c = W'(trial - dvs_ext);
    end
  end

endmodule

// File: rtl/seq_signed_div.sv
// Multi-cycle signed divider (truncating toward zero) behind valid/ready handshakes.
module seq_signed_div
  import seq_div_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero,
  output logic          overflow
);

  localparam int unsigned RW = VW + 1;
  localparam int unsigned CW = cnt_width(DW);
  localparam logic [CW-1:0] CNT_INIT = CW'(DW - 1);

  state_t        state;
  logic [DW-1:0] dvd_q;
  logic [RW-1:0] dvs_abs;
  logic [RW-1:0] prem;
  logic [CW-1:0] cnt;
  logic          dvd_neg;
  logic          dvs_neg;

  logic [DW-1:0] abs_dvd_c;
  logic [RW-1:0] sext_dvs_c;
  logic [RW-1:0] abs_dvs_c;
  logic [RW-1:0] step_rem_c;
  logic          step_q_c;

  // Magnitudes at the accept edge; the extra divisor bit holds |-2^(VW-1)|.
  assign abs_dvd_c  = dividend[DW-1] ? DW'(-dividend) : dividend;
  assign sext_dvs_c = {divisor[VW-1], divisor};
  assign abs_dvs_c  = divisor[VW-1] ? RW'(-sext_dvs_c) : sext_dvs_c;

  div_step #(.W(RW)) u_step (
    .prem       (prem),
    .din        (dvd_q[DW-1]),
    .dvs        (dvs_abs),
    .rem_next_c (step_rem_c),
    .q_bit_c    (step_q_c)
  );

  // dvd_q shifts the dividend out of its top while quotient bits enter at the bottom.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      dvd_q       <= '0;
      dvs_abs     <= '0;
      prem        <= '0;
      cnt         <= '0;
      dvd_neg     <= 1'b0;
      dvs_neg     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            dvd_q    <= abs_dvd_c;
            dvs_abs  <= abs_dvs_c;
            dvd_neg  <= dividend[DW-1];
            dvs_neg  <= divisor[VW-1];
            prem     <= '0;
            cnt      <= CNT_INIT;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end

        CALC: begin
          prem  <= step_rem_c;
          dvd_q <= {dvd_q[DW-2:0], step_q_c};
          cnt   <= cnt - CW'(1);
          if (cnt == '0) begin
            state <= FIX;
          end
        end

        FIX: begin
          quotient    <= (dvd_neg ^ dvs_neg) ? DW'(-dvd_q) : dvd_q;
          remainder   <= VW'(dvd_neg ? RW'(-prem) : prem);
          div_by_zero <= 1'b0;
          // A positive magnitude with the top bit set only arises from -2^(DW-1) / -1.
          overflow    <= ~(dvd_neg ^ dvs_neg) & dvd_q[DW-1];
          out_valid   <= 1'b1;
          state       <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
